// File: rtl/arb_pkg.sv
// Memory arbiter shared types: FSM state, grant selector, starve counter width.
package arb_pkg;
    typedef enum logic [1:0] {IDLE, IACC, DACC} arb_state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} arb_grant_t;
    localparam int unsigned STARVE_W = 4;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide type definitions.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_starve_ctr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] max,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear, or step toward max and hold there.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q < max))
            cnt_d = cnt_q + W'(1);
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data accesses win, a starvation counter forces a
// pending fetch through after STARVE_MAX consecutive data grants.
// Optional statistics outputs are enabled by defining MEM_ARBITER_STATS_EN.
module mem_arbiter
    import arb_pkg::*;
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [ADDR_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic              dwait,
    output logic [ADDR_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
`ifdef MEM_ARBITER_STATS_EN
    output word_t             icount,
    output word_t             dcount,
    output logic [15:0]       starve_hits,
`endif
    input  logic              ram_ready
);
    arb_state_t           state_q, state_d;
    arb_grant_t           grant;
    logic [STARVE_W-1:0]  starve_cnt;
    logic                 dreq, force_fetch;
    logic                 i_done, d_done;
    logic                 cnt_inc, cnt_clr;

    assign dreq        = dREN | dWEN;
    assign force_fetch = iREN && (starve_cnt == STARVE_W'(STARVE_MAX));
    assign cnt_inc     = d_done & iREN;
    assign cnt_clr     = i_done | (d_done & ~iREN);

    arb_starve_ctr #(.W(STARVE_W)) u_starve (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .max   (STARVE_W'(STARVE_MAX)),
        .cnt   (starve_cnt)
    );

    // Arbitration, RAM strobes and requester handshakes.
    always_comb begin
        state_d  = state_q;
        grant    = GNT_NONE;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = iREN;
        dwait    = dreq;
        i_done   = 1'b0;
        d_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (force_fetch)  grant = GNT_I;
                else if (dreq)    grant = GNT_D;
                else if (iREN)    grant = GNT_I;
                case (grant)
                    GNT_I:   state_d = IACC;
                    GNT_D:   state_d = DACC;
                    default: state_d = IDLE;
                endcase
            end
            IACC: begin
                // Dropped request leaves all RAM outputs idle this cycle.
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_ready) begin
                        iwait   = 1'b0;
                        iload   = ramload;
                        i_done  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DACC: begin
                if (!dreq) begin
                    state_d = IDLE;
                end else begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN   = 1'b1;
                    end
                    if (ram_ready) begin
                        dwait   = 1'b0;
                        dload   = dWEN ? '0 : ramload;
                        d_done  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

`ifdef MEM_ARBITER_STATS_EN
    word_t icount_q, icount_d, dcount_q, dcount_d;

    // Completion counters, free-running with natural wrap.
    always_comb begin
        icount_d = icount_q + word_t'(i_done);
        dcount_d = dcount_q + word_t'(d_done);
    end

    // Completion counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount_q <= '0;
            dcount_q <= '0;
        end else begin
            icount_q <= icount_d;
            dcount_q <= dcount_d;
        end
    end

    assign icount = icount_q;
    assign dcount = dcount_q;

    arb_starve_ctr #(.W(16)) u_hits (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   ((state_q == IDLE) && force_fetch),
        .clr   (1'b0),
        .max   (16'hFFFF),
        .cnt   (starve_hits)
    );
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_mem_arbiter;
    localparam int unsigned STARVE = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ram_ready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARBITER_STATS_EN
    logic [31:0] icount, dcount;
    logic [15:0] starve_hits;
`endif

    mem_arbiter #(.STARVE_MAX(STARVE), .ADDR_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload),
`ifdef MEM_ARBITER_STATS_EN
        .icount(icount), .dcount(dcount), .starve_hits(starve_hits),
`endif
        .ram_ready(ram_ready)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Model: who owns the RAM (0 none, 1 fetch, 2 data) and the data streak.
    int m_phase, m_streak, n_phase, n_streak;
    int m_icount, m_dcount, m_hits;
    logic        e_iwait, e_dwait, e_ramREN, e_ramWEN;
    logic [31:0] e_iload, e_dload, e_ramaddr, e_ramstore;
    bit          i_done, d_done, force_g;

    // Snapshot of DUT outputs from the most recent tick.
    logic        s_iwait, s_dwait, s_ramREN, s_ramWEN;
    logic [31:0] s_iload, s_dload, s_ramaddr, s_ramstore;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_streak = 0;
        m_icount = 0; m_dcount = 0; m_hits = 0;
    endtask

    // Expected outputs for this cycle from the arbitration rules.
    task automatic model_eval();
        bit dreq;
        dreq = dREN | dWEN;
        e_ramREN = 0; e_ramWEN = 0; e_ramaddr = '0; e_ramstore = '0;
        e_iload = '0; e_dload = '0; e_iwait = iREN; e_dwait = dreq;
        i_done = 0; d_done = 0; force_g = 0;
        n_phase = m_phase; n_streak = m_streak;
        case (m_phase)
            0: begin
                force_g = iREN && (m_streak == STARVE);
                if (iREN && (force_g || !dreq)) n_phase = 1;
                else if (dreq)                  n_phase = 2;
            end
            1: begin
                if (!iREN) n_phase = 0;
                else begin
                    e_ramREN = 1; e_ramaddr = iaddr;
                    if (ram_ready) begin
                        e_iwait = 0; e_iload = ramload; i_done = 1;
                        n_phase = 0; n_streak = 0;
                    end
                end
            end
            default: begin
                if (!dreq) n_phase = 0;
                else begin
                    e_ramaddr = daddr;
                    if (dWEN) begin e_ramWEN = 1; e_ramstore = dstore; end
                    else      e_ramREN = 1;
                    if (ram_ready) begin
                        e_dwait = 0; e_dload = dWEN ? 32'h0 : ramload; d_done = 1;
                        n_phase = 0;
                        n_streak = iREN ? ((m_streak + 1 > STARVE) ? STARVE : m_streak + 1) : 0;
                    end
                end
            end
        endcase
    endtask

    // One clock: check outputs mid-cycle, then advance the model past the edge.
    task automatic tick();
        @(negedge CLK); #1;
        model_eval();
        s_iwait = iwait; s_dwait = dwait; s_ramREN = ramREN; s_ramWEN = ramWEN;
        s_iload = iload; s_dload = dload; s_ramaddr = ramaddr; s_ramstore = ramstore;
        chk("ramREN",   32'(ramREN),  32'(e_ramREN));
        chk("ramWEN",   32'(ramWEN),  32'(e_ramWEN));
        chk("ramaddr",  ramaddr,      e_ramaddr);
        chk("ramstore", ramstore,     e_ramstore);
        chk("iwait",    32'(iwait),   32'(e_iwait));
        chk("iload",    iload,        e_iload);
        chk("dwait",    32'(dwait),   32'(e_dwait));
        chk("dload",    dload,        e_dload);
`ifdef MEM_ARBITER_STATS_EN
        chk("icount",      icount,            32'(m_icount));
        chk("dcount",      dcount,            32'(m_dcount));
        chk("starve_hits", 32'(starve_hits),  32'(m_hits));
`endif
        @(posedge CLK); #1;
        m_phase = n_phase; m_streak = n_streak;
        m_icount += int'(i_done); m_dcount += int'(d_done);
        if (force_g && m_hits < 16'hFFFF) m_hits++;
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    endtask

    task automatic do_reset();
        nRST = 0; #7;
        @(posedge CLK); #1;
        nRST = 1;
        model_reset();
    endtask

    initial begin
        int dcnt;
        bit got_fetch;

        // Reset values, with requests present to see wait pass-through.
        idle_inputs();
        nRST = 0;
        iREN = 1; dWEN = 1; ramload = 32'hFFFF_FFFF;
        #3;
        chk("rst_ramREN",  32'(ramREN),  32'd0);
        chk("rst_ramWEN",  32'(ramWEN),  32'd0);
        chk("rst_ramaddr", ramaddr,      32'd0);
        chk("rst_iwait",   32'(iwait),   32'd1);
        chk("rst_dwait",   32'(dwait),   32'd1);
        chk("rst_dload",   dload,        32'd0);
        idle_inputs();
        do_reset();

        // Lone fetch.
        iREN = 1; iaddr = 32'h40;
        tick();
        chk("lf_idle_ramREN", 32'(s_ramREN), 32'd0);
        tick();
        chk("lf_c1_ramREN",  32'(s_ramREN), 32'd1);
        chk("lf_c1_ramaddr", s_ramaddr,     32'h40);
        chk("lf_c1_iwait",   32'(s_iwait),  32'd1);
        ram_ready = 1; ramload = 32'hDEADBEEF;
        tick();
        chk("lf_c2_iwait", 32'(s_iwait), 32'd0);
        chk("lf_c2_iload", s_iload,      32'hDEADBEEF);
        chk("lf_c2_dwait", 32'(s_dwait), 32'd0);
        idle_inputs(); tick();

        // Simultaneous fetch and write: data first, fetch after one IDLE.
        do_reset();
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h80; dstore = 32'h1234; ram_ready = 1;
        tick();
        tick();
        chk("sim_ramWEN",   32'(s_ramWEN), 32'd1);
        chk("sim_ramstore", s_ramstore,    32'h1234);
        chk("sim_ramaddr",  s_ramaddr,     32'h80);
        chk("sim_iwait",    32'(s_iwait),  32'd1);
        dWEN = 0;
        tick();
        chk("sim_idle_ramREN", 32'(s_ramREN), 32'd0);
        tick();
        chk("sim_iacc_ramREN", 32'(s_ramREN), 32'd1);
        chk("sim_iacc_iwait",  32'(s_iwait),  32'd0);
        idle_inputs(); tick();

        // Starvation: two rounds of exactly STARVE data grants then a fetch.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            iREN = 1; iaddr = 32'h100 + 32'(r); dREN = 1; daddr = 32'h200; ram_ready = 1; ramload = 32'h55;
            dcnt = 0; got_fetch = 0;
            for (int c = 0; c < 40 && !got_fetch; c++) begin
                tick();
                if (!s_dwait) dcnt++;
                if (!s_iwait) got_fetch = 1;
            end
            chk("starve_fetch_granted", 32'(got_fetch), 32'd1);
            chk("starve_dcount",        32'(dcnt),      32'(STARVE));
        end
        idle_inputs(); tick();

        // Abort: read dropped in first DACC cycle.
        do_reset();
        dREN = 1; daddr = 32'h300;
        tick();
        dREN = 0;
        tick();
        chk("abort_ramREN", 32'(s_ramREN), 32'd0);
        chk("abort_dwait",  32'(s_dwait),  32'd0);
        ram_ready = 1;
        tick();
        chk("abort_idle_ramREN", 32'(s_ramREN), 32'd0);
        idle_inputs(); tick();

        // Read and write together: write wins, dload is zero.
        do_reset();
        dREN = 1; dWEN = 1; daddr = 32'h84; dstore = 32'hCAFE; ram_ready = 1; ramload = 32'hFFFF_0000;
        tick();
        tick();
        chk("rw_ramWEN", 32'(s_ramWEN), 32'd1);
        chk("rw_ramREN", 32'(s_ramREN), 32'd0);
        chk("rw_dwait",  32'(s_dwait),  32'd0);
        chk("rw_dload",  s_dload,       32'd0);
        idle_inputs(); tick();

        // Asynchronous reset mid-DACC, request held through reset.
        do_reset();
        dWEN = 1; daddr = 32'h88; dstore = 32'h77;
        tick();
        tick();
        chk("ar_pre_ramWEN", 32'(s_ramWEN), 32'd1);
        #2 nRST = 0;
        #1;
        chk("ar_ramWEN",  32'(ramWEN),  32'd0);
        chk("ar_ramaddr", ramaddr,      32'd0);
        chk("ar_dwait",   32'(dwait),   32'd1);
        model_reset();
        @(posedge CLK); #1;
        nRST = 1;
        tick();
        chk("ar_idle_ramWEN", 32'(s_ramWEN), 32'd0);
        tick();
        chk("ar_regrant_ramWEN", 32'(s_ramWEN), 32'd1);
        idle_inputs(); tick();

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tick();
            if (iREN) begin
                if (i_done) begin iREN = 1'($urandom_range(0, 1)); iaddr = $urandom; end
                else if ($urandom_range(0, 19) == 0) iREN = 0;
            end else begin
                iREN = 1'($urandom_range(0, 1)); iaddr = $urandom;
            end
            if (dREN | dWEN) begin
                if (d_done) begin
                    {dWEN, dREN} = 2'($urandom_range(0, 3)); daddr = $urandom; dstore = $urandom;
                end else if ($urandom_range(0, 19) == 0) begin
                    dREN = 0; dWEN = 0;
                end
            end else if ($urandom_range(0, 1) == 1) begin
                {dWEN, dREN} = 2'($urandom_range(1, 3)); daddr = $urandom; dstore = $urandom;
            end
            ram_ready = ($urandom_range(0, 2) == 0);
            ramload = $urandom;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
